// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search helper for the FIFO port arbiters.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int unsigned BEAT_CNT_W = 5;
  localparam int unsigned MAX_REQ    = 8;

  // First set index after `last`, wrapping modulo n; 0 when nothing is set.
  function automatic int unsigned rr_next(input logic [MAX_REQ-1:0] req,
                                          input int unsigned        last,
                                          input int unsigned        n);
    int unsigned idx;
    int unsigned cand;
    logic        hit;
    idx = 32'd0;
    hit = 1'b0;
    for (int unsigned k = 32'd1; k <= MAX_REQ; k++) begin
      cand = (last + k) % n;
      if ((k <= n) && !hit && req[cand[2:0]]) begin
        idx = cand;
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: given the request vector and the last
// winner, reports whether anyone is requesting and which index wins next.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [MAX_REQ-1:0] req_ext;

  // Zero-extend the request vector to the helper's fixed width.
  always_comb begin
    req_ext                = {MAX_REQ{1'b0}};
    req_ext[NUM_REQ-1:0]   = req;
  end

  assign found = |req;
  assign idx   = IDX_W'(rr_next(req_ext, 32'(last), NUM_REQ));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async_fifo write port among
// NUM_REQ producers in the wclk domain; never issues a beat while wfull.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                         wclk,
  input  logic                         wrstn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  input  logic                         wfull,
  output logic                         winc,
  output logic [DATA_SIZE-1:0]         wdata,
  output logic                         busy,
  output logic [IDX_W-1:0]             owner
);

  localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(MAX_BURST - 1);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  take;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign take = (state_q == OWN) && req[owner_q] && !wfull;

  // State register: FSM state, grant owner, fairness pointer and beat count.
  always_ff @(posedge wclk) begin
    if (!wrstn) begin
      state_q    <= IDLE;
      owner_q    <= {IDX_W{1'b0}};
      last_q     <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q <= {BEAT_CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state: grant in IDLE, count beats and release in OWN.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = {BEAT_CNT_W{1'b0}};
          state_d    = OWN;
        end else begin
          state_d    = IDLE;
        end
      end
      OWN: begin
        if (take) begin
          beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
        // A stalled owner keeps the port; only a dropped request or a
        // completed burst releases it.
        if (!req[owner_q] || (take && (beat_cnt_q == BEAT_LAST))) begin
          state_d    = IDLE;
          last_d     = owner_q;
          beat_cnt_d = {BEAT_CNT_W{1'b0}};
        end else begin
          state_d    = OWN;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = {BEAT_CNT_W{1'b0}};
      end
    endcase
  end

  // Output mux: forward the owner's beat only when the FIFO accepts it.
  always_comb begin
    ack   = {NUM_REQ{1'b0}};
    winc  = 1'b0;
    wdata = {DATA_SIZE{1'b0}};
    if (take) begin
      winc         = 1'b1;
      ack[owner_q] = 1'b1;
      wdata        = req_data[owner_q*DATA_SIZE +: DATA_SIZE];
    end else begin
      winc         = 1'b0;
    end
  end

  assign busy  = (state_q == OWN);
  assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: default build plus a MAX_BURST=1 build.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrstn;
  logic [3:0]  req, req_b;
  logic [31:0] req_data, req_data_b;
  logic        wfull, wfull_b;
  logic [3:0]  ack, ack_b;
  logic        winc, winc_b;
  logic [7:0]  wdata, wdata_b;
  logic        busy, busy_b;
  logic [1:0]  owner, owner_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_SIZE(8), .MAX_BURST(4)) u_dut (
    .wclk(wclk), .wrstn(wrstn), .req(req), .req_data(req_data), .ack(ack),
    .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy), .owner(owner)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_SIZE(8), .MAX_BURST(1)) u_dut_mb1 (
    .wclk(wclk), .wrstn(wrstn), .req(req_b), .req_data(req_data_b), .ack(ack_b),
    .wfull(wfull_b), .winc(winc_b), .wdata(wdata_b), .busy(busy_b), .owner(owner_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on the default build: drive after the edge, then check.
  task automatic step(input string tag, input logic [3:0] r, input logic [31:0] d,
                      input logic f, input logic e_busy, input logic [1:0] e_own,
                      input logic [3:0] e_ack, input logic [7:0] e_wdata);
    @(posedge wclk);
    #1;
    req = r; req_data = d; wfull = f;
    #1;
    check_eq({tag, ".busy"},  32'(busy),  32'(e_busy));
    check_eq({tag, ".winc"},  32'(winc),  32'(|e_ack));
    check_eq({tag, ".ack"},   32'(ack),   32'(e_ack));
    check_eq({tag, ".wdata"}, 32'(wdata), 32'(e_wdata));
    if (e_busy) check_eq({tag, ".owner"}, 32'(owner), 32'(e_own));
  endtask

  // One cycle on the MAX_BURST=1 build.
  task automatic step_b(input string tag, input logic [3:0] r, input logic [31:0] d,
                        input logic e_busy, input logic [1:0] e_own,
                        input logic [3:0] e_ack, input logic [7:0] e_wdata);
    @(posedge wclk);
    #1;
    req_b = r; req_data_b = d; wfull_b = 1'b0;
    #1;
    check_eq({tag, ".busy"},  32'(busy_b),  32'(e_busy));
    check_eq({tag, ".winc"},  32'(winc_b),  32'(|e_ack));
    check_eq({tag, ".ack"},   32'(ack_b),   32'(e_ack));
    check_eq({tag, ".wdata"}, 32'(wdata_b), 32'(e_wdata));
    if (e_busy) check_eq({tag, ".owner"}, 32'(owner_b), 32'(e_own));
  endtask

  initial begin
    logic [7:0] v;
    int seq [5] = '{0, 1, 2, 3, 0};

    wrstn = 1'b0; req = 4'b0; req_data = 32'h0; wfull = 1'b0;
    req_b = 4'b0; req_data_b = 32'h0; wfull_b = 1'b0;

    // Reset state
    step("rst0", 4'b0, 32'h0, 1'b0, 1'b0, 2'd0, 4'b0, 8'h00);
    step("rst1", 4'b0, 32'h0, 1'b0, 1'b0, 2'd0, 4'b0, 8'h00);
    check_eq("rst.owner", 32'(owner), 32'd0);
    check_eq("rst_b.busy", 32'(busy_b), 32'd0);
    wrstn = 1'b1;

    // Single requester: 4-beat burst, one IDLE cycle, re-grant to 0
    step("t1.idle", 4'b0001, 32'h0000_00A0, 1'b0, 1'b0, 2'd0, 4'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      v = 8'hA0 + 8'(i);
      step("t1.beat", 4'b0001, {24'h0, v}, 1'b0, 1'b1, 2'd0, 4'b0001, v);
    end
    step("t1.gap",     4'b0001, 32'h0000_00A4, 1'b0, 1'b0, 2'd0, 4'b0,    8'h00);
    step("t1.regrant", 4'b0001, 32'h0000_00A4, 1'b0, 1'b1, 2'd0, 4'b0001, 8'hA4);
    step("t1.drop",    4'b0000, 32'h0000_00A5, 1'b0, 1'b1, 2'd0, 4'b0,    8'h00);
    step("t1.idle2",   4'b0000, 32'h0,         1'b0, 1'b0, 2'd0, 4'b0,    8'h00);

    // Reset mid-burst while last=0: first grant afterwards must be index 0
    step("t6.idle", 4'b0100, 32'h00E2_0000, 1'b0, 1'b0, 2'd0, 4'b0,    8'h00);
    step("t6.own",  4'b0100, 32'h00E2_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 8'hE2);
    wrstn = 1'b0;
    step("t6.rst",  4'b1001, 32'hE300_00E0, 1'b0, 1'b0, 2'd0, 4'b0,    8'h00);
    wrstn = 1'b1;
    step("t6.grant", 4'b1001, 32'hE300_00E0, 1'b0, 1'b1, 2'd0, 4'b0001, 8'hE0);
    step("t6.drop",  4'b0000, 32'h0,         1'b0, 1'b1, 2'd0, 4'b0,    8'h00);
    step("t6.idle2", 4'b0000, 32'h0,         1'b0, 1'b0, 2'd0, 4'b0,    8'h00);

    // All requesting: owners 0,1,2,3,0 with 4 beats each
    wrstn = 1'b0;
    step("t2.rst", 4'b0, 32'h0, 1'b0, 1'b0, 2'd0, 4'b0, 8'h00);
    wrstn = 1'b1;
    foreach (seq[g]) begin
      step("t2.idle", 4'b1111, 32'hC3C2_C1C0, 1'b0, 1'b0, 2'd0, 4'b0, 8'h00);
      for (int b = 0; b < 4; b++) begin
        step("t2.beat", 4'b1111, 32'hC3C2_C1C0, 1'b0, 1'b1, 2'(seq[g]),
             4'(1 << seq[g]), 8'hC0 + 8'(seq[g]));
      end
    end
    step("t2.end", 4'b0000, 32'h0, 1'b0, 1'b0, 2'd0, 4'b0, 8'h00);

    // Owner 2 stalled by wfull for 3 cycles after its first beat
    step("t3.idle", 4'b0100, 32'h0050_0000, 1'b0, 1'b0, 2'd0, 4'b0,    8'h00);
    step("t3.b0",   4'b0100, 32'h0050_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 8'h50);
    for (int s = 0; s < 3; s++)
      step("t3.stall", 4'b0100, 32'h0051_0000, 1'b1, 1'b1, 2'd2, 4'b0, 8'h00);
    step("t3.b1",  4'b0100, 32'h0051_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 8'h51);
    step("t3.b2",  4'b0100, 32'h0052_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 8'h52);
    step("t3.b3",  4'b0100, 32'h0053_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 8'h53);
    step("t3.end", 4'b0000, 32'h0,         1'b0, 1'b0, 2'd0, 4'b0,    8'h00);

    // Owner 1 drops after 2 beats; next grant skips to 3
    step("t4.idle",  4'b0010, 32'h7300_6100, 1'b0, 1'b0, 2'd0, 4'b0,    8'h00);
    step("t4.b0",    4'b1010, 32'h7300_6100, 1'b0, 1'b1, 2'd1, 4'b0010, 8'h61);
    step("t4.b1",    4'b1010, 32'h7300_6200, 1'b0, 1'b1, 2'd1, 4'b0010, 8'h62);
    step("t4.drop",  4'b1000, 32'h7300_0000, 1'b0, 1'b1, 2'd1, 4'b0,    8'h00);
    step("t4.idle2", 4'b1000, 32'h7300_0000, 1'b0, 1'b0, 2'd0, 4'b0,    8'h00);
    step("t4.own3",  4'b1000, 32'h7300_0000, 1'b0, 1'b1, 2'd3, 4'b1000, 8'h73);
    step("t4.end",   4'b0000, 32'h0,         1'b0, 1'b1, 2'd3, 4'b0,    8'h00);
    step("t4.fin",   4'b0000, 32'h0,         1'b0, 1'b0, 2'd0, 4'b0,    8'h00);

    // MAX_BURST=1 build: strict alternation 0,2,0,2 with IDLE between
    for (int i = 0; i < 4; i++) begin
      step_b("t5.idle", 4'b0101, 32'h00B2_00B0, 1'b0, 2'd0, 4'b0, 8'h00);
      if (i % 2 == 0)
        step_b("t5.own0", 4'b0101, 32'h00B2_00B0, 1'b1, 2'd0, 4'b0001, 8'hB0);
      else
        step_b("t5.own2", 4'b0101, 32'h00B2_00B0, 1'b1, 2'd2, 4'b0100, 8'hB2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
